fifo_tx_ctrl: RTL and testbench
===============================

FIFO_TX_CTRL -- requirements
Module: fifo_tx_ctrl

Interface
REQ-001 Parameter: width, 8, data byte width; same value as the upstream FIFO.
REQ-002 Parameter: BUSY_TO, 15, max cycles to wait for TX_Busy to rise after a TX_valid pulse before retrying.
REQ-003 CLK  in  1  single system clock; all state on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 Embty  in  1  upstream FIFO empty flag.
REQ-006 FIFO_Data  in  width  upstream FIFO read data.
REQ-007 FIFO_valid  in  1  upstream FIFO read-valid; toggles once per completed read.
REQ-008 ALU_valid  in  1  FIFO write source busy; reads are blocked while high.
REQ-009 RD_valid  in  1  FIFO write source busy; reads are blocked while high.
REQ-010 TX_Busy  in  1  UART transmitter busy.
REQ-011 RD_EN  out  1  FIFO read request.
REQ-012 TX_Data  out  width  byte presented to the UART transmitter.
REQ-013 TX_valid  out  1  one-cycle start pulse to the UART transmitter.
REQ-014 Sent_cnt  out  8  count of bytes whose transmission has completed; wraps 255->0.
REQ-015 Retry_err  out  1  sticky flag, set on any busy timeout.

Function
REQ-016 FSM states: IDLE, FETCH, WAIT_DATA, SEND, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE->FETCH when !Embty && !ALU_valid && !RD_valid; otherwise stay in IDLE.
REQ-018 RD_EN = 1 only in FETCH (Moore decode of registered state), exactly one cycle per fetch; FETCH->WAIT_DATA unconditionally.
REQ-019 Internal valid_q holds the last accepted FIFO_valid level.
REQ-020 WAIT_DATA: if FIFO_valid != valid_q, latch FIFO_Data into TX_Data, set valid_q <= FIFO_valid, go to SEND.
REQ-021 WAIT_DATA: if FIFO_valid == valid_q (read blocked by a concurrent write), return to IDLE; no byte is consumed and TX_Data is held.
REQ-022 SEND: TX_valid = 1 for exactly one cycle; clear the timeout counter; go to WAIT_BUSY.
REQ-023 WAIT_BUSY: TX_Busy = 1 -> WAIT_DONE; otherwise increment the counter; counter == BUSY_TO -> set Retry_err, go to SEND with the same TX_Data.
REQ-024 WAIT_DONE: TX_Busy = 0 -> increment Sent_cnt, go to IDLE.
REQ-025 TX_Data is stable from SEND through WAIT_DONE exit.
REQ-026 Latency: 3 cycles from IDLE with !Embty to the TX_valid pulse (FETCH, WAIT_DATA, SEND).
REQ-027 At most one byte is in flight; no fetch occurs before WAIT_DONE exits.
REQ-028 TX_Busy already high at SEND counts as busy-rise on the next cycle.
REQ-029 Embty rising during FETCH/WAIT_DATA is ignored; the REQ-020/021 toggle check alone decides acceptance.

Reset
REQ-030 Reset low forces IDLE immediately, with RD_EN=0, TX_valid=0, TX_Data=0, Sent_cnt=0, Retry_err=0, valid_q=0, and the counter cleared.
REQ-031 Reset mid-transfer abandons the byte; there is no recovery attempt; valid_q=0 matches the FIFO's own reset value of valid.

Structure
REQ-032 The shared package holds the state enumeration and the BUSY_TO default.
REQ-033 One sub-module, busy_timer: a clearable, saturating counter with a terminal-count output, instantiated once.

Verification
REQ-034 FIFO holding 0xA5, TX_Busy rises one cycle after TX_valid and stays high 10 cycles -> RD_EN for 1 cycle, TX_valid 3 cycles after start, TX_Data=0xA5, Sent_cnt=1.
REQ-035 ALU_valid asserted in the FETCH cycle, so FIFO_valid does not toggle -> return to IDLE, no TX_valid, refetch once ALU_valid is low, byte sent once.
REQ-036 TX_Busy held low for 20 cycles -> TX_valid re-pulses after BUSY_TO=15 cycles in WAIT_BUSY with the same TX_Data, Retry_err=1.
REQ-037 Four bytes 0x01..0x04 queued -> sent in order, each TX_valid only after the previous busy falls, Sent_cnt=4, Embty ends high.
REQ-038 Reset pulse during WAIT_DONE -> all outputs at reset values; next FIFO byte fetched and sent normally.
REQ-039 256 completed bytes -> Sent_cnt wraps to 0.

Source files
------------

// File: rtl/fifo_tx_ctrl_pkg.sv
// Shared definitions for the FIFO-to-UART transmit controller.
package fifo_tx_ctrl_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int BUSY_TO_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/fifo_tx_ctrl_busy_timer.sv
// Clearable saturating counter; o_tc flags the increment that reaches LIMIT.
module fifo_tx_ctrl_busy_timer
    import fifo_tx_ctrl_pkg::*;
#(
    parameter int LIMIT = BUSY_TO_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] TOP  = CW'(LIMIT);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != TOP)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = i_inc && (r_count == LAST);

endmodule

// File: rtl/fifo_tx_ctrl.sv
// Pulls one byte at a time from the upstream FIFO and hands it to the UART,
// retrying the start pulse when the transmitter never reports busy.
module fifo_tx_ctrl
    import fifo_tx_ctrl_pkg::*;
#(
    parameter int width   = WIDTH_DEF,
    parameter int BUSY_TO = BUSY_TO_DEF
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Embty,
    input  logic [width-1:0] FIFO_Data,
    input  logic             FIFO_valid,
    input  logic             ALU_valid,
    input  logic             RD_valid,
    input  logic             TX_Busy,
    output logic             RD_EN,
    output logic [width-1:0] TX_Data,
    output logic             TX_valid,
    output logic [7:0]       Sent_cnt,
    output logic             Retry_err
);

    state_t r_state;
    state_t w_next;
    logic   r_valid_q;
    logic   w_tmr_clr;
    logic   w_tmr_inc;
    logic   w_tmr_tc;
    logic   w_accept;
    logic   w_done;
    logic   w_timeout;

    // A read only counts when the FIFO's valid level has moved since the last accepted byte.
    assign w_accept  = (r_state == WAIT_DATA) && (FIFO_valid != r_valid_q);
    assign w_done    = (r_state == WAIT_DONE) && !TX_Busy;
    assign w_timeout = w_tmr_tc;

    fifo_tx_ctrl_busy_timer #(
        .LIMIT (BUSY_TO)
    ) busy_timer (
        .clk   (CLK),
        .rst_n (Reset),
        .i_clr (w_tmr_clr),
        .i_inc (w_tmr_inc),
        .o_tc  (w_tmr_tc)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (!Embty && !ALU_valid && !RD_valid) w_next = FETCH;
            FETCH:     w_next = WAIT_DATA;
            WAIT_DATA: w_next = w_accept ? SEND : IDLE;
            SEND:      w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (TX_Busy) begin
                    w_next = WAIT_DONE;
                end else if (w_timeout) begin
                    w_next = SEND;
                end
            end
            WAIT_DONE: if (!TX_Busy) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        RD_EN     = (r_state == FETCH);
        TX_valid  = (r_state == SEND);
        w_tmr_clr = (r_state == SEND);
        w_tmr_inc = (r_state == WAIT_BUSY) && !TX_Busy;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            TX_Data   <= '0;
            r_valid_q <= 1'b0;
            Sent_cnt  <= '0;
            Retry_err <= 1'b0;
        end else begin
            if (w_accept) begin
                TX_Data   <= FIFO_Data;
                r_valid_q <= FIFO_valid;
            end
            if (w_done) begin
                Sent_cnt <= Sent_cnt + 8'd1;
            end
            if (w_timeout) begin
                Retry_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_tx_ctrl.sv
// Directed bench for fifo_tx_ctrl with a small FIFO stub and UART busy model.
module tb_fifo_tx_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Embty;
    logic [7:0] FIFO_Data;
    logic       FIFO_valid;
    logic       ALU_valid;
    logic       RD_valid;
    logic       TX_Busy;
    logic       RD_EN;
    logic [7:0] TX_Data;
    logic       TX_valid;
    logic [7:0] Sent_cnt;
    logic       Retry_err;

    always #5 CLK = ~CLK;

    fifo_tx_ctrl #(
        .width   (8),
        .BUSY_TO (15)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Embty      (Embty),
        .FIFO_Data  (FIFO_Data),
        .FIFO_valid (FIFO_valid),
        .ALU_valid  (ALU_valid),
        .RD_valid   (RD_valid),
        .TX_Busy    (TX_Busy),
        .RD_EN      (RD_EN),
        .TX_Data    (TX_Data),
        .TX_valid   (TX_valid),
        .Sent_cnt   (Sent_cnt),
        .Retry_err  (Retry_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] tx_log[$];
    int rd_cnt, tx_cnt, first_tx_cyc, prev_tx_cyc, last_tx_cyc, overlap;
    int busy_len  = 1;
    int busy_left = 0;
    int mute      = 0;
    int start_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample DUT at the falling edge, update the stubs just after the rising edge.
    task automatic tick();
        logic rd_go;
        logic tx_go;
        @(negedge CLK);
        cyc++;
        if (RD_EN) rd_cnt++;
        if (TX_valid) begin
            tx_cnt++;
            prev_tx_cyc = last_tx_cyc;
            last_tx_cyc = cyc;
            if (tx_cnt == 1) first_tx_cyc = cyc;
            tx_log.push_back(TX_Data);
            if (TX_Busy) overlap++;
        end
        rd_go = RD_EN && !ALU_valid && !RD_valid && (fifo_q.size() > 0);
        if (mute > 0) mute--;
        tx_go = TX_valid && (mute == 0);
        @(posedge CLK);
        #1;
        if (rd_go) begin
            FIFO_Data  = fifo_q.pop_front();
            FIFO_valid = ~FIFO_valid;
        end
        Embty = (fifo_q.size() == 0);
        if (tx_go) begin
            TX_Busy   = 1'b1;
            busy_left = busy_len;
        end else if (TX_Busy) begin
            busy_left--;
            if (busy_left == 0) TX_Busy = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        Embty = 1'b0;
    endtask

    task automatic clear_stats();
        rd_cnt  = 0;
        tx_cnt  = 0;
        overlap = 0;
        tx_log.delete();
    endtask

    task automatic wait_sent(input logic [7:0] exp, input int budget, input string tag);
        int n = 0;
        while (Sent_cnt !== exp && n < budget) begin
            tick();
            n++;
        end
        check(tag, Sent_cnt, exp);
    endtask

    task automatic wait_tx(input int target, input int budget, input string tag);
        int n = 0;
        while (tx_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, tx_cnt, target);
    endtask

    initial begin
        Reset      = 1'b0;
        Embty      = 1'b1;
        FIFO_Data  = 8'h00;
        FIFO_valid = 1'b0;
        ALU_valid  = 1'b0;
        RD_valid   = 1'b0;
        TX_Busy    = 1'b0;
        clear_stats();

        // Reset state
        repeat (2) tick();
        check("reset_rd_en",     RD_EN,     0);
        check("reset_tx_valid",  TX_valid,  0);
        check("reset_tx_data",   TX_Data,   0);
        check("reset_sent_cnt",  Sent_cnt,  0);
        check("reset_retry_err", Retry_err, 0);
        Reset = 1'b1;
        repeat (2) tick();

        // Single byte, busy for 10 cycles
        clear_stats();
        busy_len  = 10;
        start_cyc = cyc + 1;
        push(8'hA5);
        wait_sent(8'd1, 60, "t1_sent_cnt");
        repeat (2) tick();
        check("t1_rd_en_cycles", rd_cnt, 1);
        check("t1_tx_pulses",    tx_cnt, 1);
        check("t1_latency",      first_tx_cyc - start_cyc, 3);
        check("t1_tx_data",      TX_Data, 8'hA5);
        check("t1_retry_err",    Retry_err, 0);

        // Read blocked by ALU_valid during FETCH
        clear_stats();
        busy_len = 3;
        push(8'h3C);
        tick();
        ALU_valid = 1'b1;
        tick();
        repeat (4) tick();
        check("t2_blocked_tx",   tx_cnt, 0);
        check("t2_blocked_rd",   rd_cnt, 1);
        check("t2_held_data",    TX_Data, 8'hA5);
        check("t2_blocked_sent", Sent_cnt, 1);
        ALU_valid = 1'b0;
        wait_sent(8'd2, 60, "t2_sent_cnt");
        repeat (2) tick();
        check("t2_refetch_rd",   rd_cnt, 2);
        check("t2_tx_pulses",    tx_cnt, 1);
        check("t2_tx_data",      TX_Data, 8'h3C);

        // Busy timeout: SEND, 15 cycles WAIT_BUSY, SEND again
        clear_stats();
        busy_len = 3;
        push(8'h5A);
        mute = 20;
        wait_tx(1, 20, "t3_first_pulse");
        check("t3_no_err_yet", Retry_err, 0);
        wait_tx(2, 40, "t3_retry_pulse");
        check("t3_retry_gap",    last_tx_cyc - prev_tx_cyc, 16);
        check("t3_retry_err",    Retry_err, 1);
        check("t3_data_first",   tx_log[0], 8'h5A);
        check("t3_data_retry",   tx_log[1], 8'h5A);
        wait_sent(8'd3, 60, "t3_sent_cnt");
        repeat (2) tick();
        check("t3_tx_pulses",    tx_cnt, 2);

        // Four queued bytes, strictly one in flight
        clear_stats();
        busy_len = 4;
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_sent(8'd7, 200, "t4_sent_cnt");
        repeat (2) tick();
        check("t4_tx_pulses", tx_cnt, 4);
        check("t4_rd_cycles", rd_cnt, 4);
        check("t4_overlap",   overlap, 0);
        for (int i = 0; i < 4; i++) check("t4_order", tx_log[i], 32'(i + 1));
        check("t4_retry_sticky", Retry_err, 1);

        // Reset during WAIT_DONE
        clear_stats();
        busy_len = 10;
        push(8'h77);
        wait_tx(1, 20, "t5_pulse");
        repeat (3) tick();
        Reset = 1'b0;
        #2;
        check("t5_rst_rd_en",     RD_EN,     0);
        check("t5_rst_tx_valid",  TX_valid,  0);
        check("t5_rst_tx_data",   TX_Data,   0);
        check("t5_rst_sent_cnt",  Sent_cnt,  0);
        check("t5_rst_retry_err", Retry_err, 0);
        TX_Busy    = 1'b0;
        busy_left  = 0;
        FIFO_valid = 1'b0;
        tick();
        Reset = 1'b1;
        clear_stats();
        push(8'h9C);
        wait_sent(8'd1, 60, "t5_sent_cnt");
        repeat (2) tick();
        check("t5_tx_data",   TX_Data, 8'h9C);
        check("t5_tx_pulses", tx_cnt, 1);
        check("t5_retry_err", Retry_err, 0);

        // Sent_cnt wrap: 1 already sent, 254 more reach 255, one more wraps to 0
        clear_stats();
        busy_len = 1;
        for (int i = 0; i < 254; i++) push(8'(i));
        wait_sent(8'd255, 3000, "t6_sent_255");
        push(8'hEE);
        wait_sent(8'd0, 60, "t6_sent_wrap");
        check("t6_tx_pulses", tx_cnt, 255);
        check("t6_last_data", TX_Data, 8'hEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
